// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: sequences the pc register and the imem req/ack port, delivering instructions to decode.
module pc_fetch_sequencer #(
  parameter logic [15:0] RESET_VEC = 16'h0000,
  parameter logic [15:0] PC_INC = 16'd2,
  parameter logic [3:0] HALT_OP = 4'hF,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic redirect,
  input  logic [15:0] redirect_target,
  input  logic resume,
  input  logic [15:0] pc_addr,
  output logic pc_enable,
  output logic [15:0] pc_in,
  output logic imem_req,
  output logic [15:0] imem_addr,
  input  logic imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic instr_valid,
  output logic halted,
  output logic fetch_err
);
  typedef enum logic [1:0] {BOOT, FETCH, WAIT, HALTED} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic pend_q, pend_d;
  logic [15:0] pend_tgt_q, pend_tgt_d;
  logic [15:0] instr_q, instr_d;
  logic instr_valid_q, instr_valid_d;
  logic halted_q, halted_d;
  logic fetch_err_q, fetch_err_d;
  logic issue, done, deliver;
  assign issue = (state_q == FETCH && !redirect && !stall) || state_q == WAIT;
  assign done = issue && imem_ack;
  assign deliver = !redirect && !pend_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      cnt_q <= '0;
      pend_q <= 1'b0;
      pend_tgt_q <= '0;
      instr_q <= '0;
      instr_valid_q <= 1'b0;
      halted_q <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      instr_q <= instr_d;
      instr_valid_q <= instr_valid_d;
      halted_q <= halted_d;
      fetch_err_q <= fetch_err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    pend_d = pend_q;
    pend_tgt_d = pend_tgt_q;
    instr_d = instr_q;
    instr_valid_d = 1'b0;
    halted_d = halted_q;
    fetch_err_d = fetch_err_q;
    if (state_q == BOOT) state_d = FETCH;
    if (state_q == FETCH && issue && !imem_ack) begin
      state_d = WAIT;
      cnt_d = '0;
    end
    if (state_q == WAIT && !imem_ack) begin
      pend_d = redirect ? 1'b1 : pend_q;
      pend_tgt_d = redirect ? redirect_target : pend_tgt_q;
      cnt_d = cnt_q + 1'b1;
      if (cnt_d == CNT_W'(TIMEOUT)) begin
        fetch_err_d = 1'b1;
        halted_d = 1'b1;
        pend_d = 1'b0;
        state_d = HALTED;
      end
    end
    if (state_q == HALTED && (redirect || resume)) begin
      halted_d = 1'b0;
      state_d = FETCH;
    end
    if (done) begin
      pend_d = 1'b0;
      instr_d = deliver ? imem_rdata : instr_q;
      instr_valid_d = deliver;
      halted_d = deliver && imem_rdata[15:12] == HALT_OP;
      state_d = halted_d ? HALTED : FETCH;
    end
  end
  always_comb begin
    imem_req = !rst && issue;
    pc_enable = !rst && (state_q == BOOT || done || (redirect && (state_q == FETCH || state_q == HALTED)));
    pc_in = state_q == BOOT ? RESET_VEC :
            !done ? redirect_target :
            redirect ? redirect_target :
            pend_q ? pend_tgt_q : pc_addr + PC_INC;
  end
  assign imem_addr = pc_addr;
  assign instr = instr_q;
  assign instr_valid = instr_valid_q;
  assign halted = halted_q;
  assign fetch_err = fetch_err_q;
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: directed scenarios with a bench-side pc register model.
module tb_pc_fetch_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1, stall = 1'b0, redirect = 1'b0, resume = 1'b0, imem_ack = 1'b0;
  logic [15:0] redirect_target = '0, imem_rdata = '0, pc = 16'hDEAD;
  logic pc_enable, imem_req, instr_valid, halted, fetch_err;
  logic [15:0] pc_in, imem_addr, instr;
  int checks = 0, failures = 0;

  pc_fetch_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
    .resume(resume), .pc_addr(pc), .pc_enable(pc_enable), .pc_in(pc_in), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .halted(halted), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (pc_enable) pc <= pc_in;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0h exp=0", imem_req); end
    checks++; if (pc_enable !== 1'b0) begin failures++; $display("FAIL rst_pc_en got=%0h exp=0", pc_enable); end
    tick(); tick();
    checks++; if (instr !== 16'h0000) begin failures++; $display("FAIL rst_instr got=%0h exp=0", instr); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", instr_valid); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted got=%0h exp=0", halted); end
    checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%0h exp=0", fetch_err); end
  endtask

  task automatic test_seq_fetch();
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 16'h1234;
    #1;
    checks++; if (pc_enable !== 1'b1 || pc_in !== 16'h0000) begin failures++; $display("FAIL boot_load got=%0h/%0h exp=1/0000", pc_enable, pc_in); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL boot_req got=%0h exp=0", imem_req); end
    tick();
    checks++; if (pc !== 16'h0000) begin failures++; $display("FAIL boot_pc got=%0h exp=0000", pc); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'(2 * i)) begin failures++; $display("FAIL seq_req[%0d] got=%0h@%0h exp=1@%0h", i, imem_req, imem_addr, 2 * i); end
      checks++; if (pc_in !== 16'(2 * i + 2)) begin failures++; $display("FAIL seq_pc_in[%0d] got=%0h exp=%0h", i, pc_in, 2 * i + 2); end
      tick();
      checks++; if (instr_valid !== 1'b1 || instr !== 16'h1234) begin failures++; $display("FAIL seq_instr[%0d] got=%0h/%0h exp=1/1234", i, instr_valid, instr); end
      checks++; if (pc !== 16'(2 * i + 2)) begin failures++; $display("FAIL seq_pc[%0d] got=%0h exp=%0h", i, pc, 2 * i + 2); end
    end
  endtask

  task automatic test_wait_states();
    imem_ack = 1'b0; imem_rdata = 16'h5678;
    for (int i = 0; i < 4; i++) begin
      imem_ack = (i == 3);
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0004) begin failures++; $display("FAIL wait_req[%0d] got=%0h@%0h exp=1@0004", i, imem_req, imem_addr); end
      checks++; if (pc_enable !== (i == 3)) begin failures++; $display("FAIL wait_pc_en[%0d] got=%0h exp=%0h", i, pc_enable, i == 3); end
      tick();
      checks++; if (instr_valid !== (i == 3)) begin failures++; $display("FAIL wait_valid[%0d] got=%0h exp=%0h", i, instr_valid, i == 3); end
    end
    checks++; if (pc !== 16'h0006 || instr !== 16'h5678) begin failures++; $display("FAIL wait_done got=%0h/%0h exp=0006/5678", pc, instr); end
  endtask

  task automatic test_redirect_wait();
    imem_ack = 1'b0; imem_rdata = 16'hAAAA;
    tick();
    redirect = 1'b1; redirect_target = 16'h0100;
    #1;
    checks++; if (imem_req !== 1'b1 || pc_enable !== 1'b0) begin failures++; $display("FAIL redir_wait_hold got=%0h/%0h exp=1/0", imem_req, pc_enable); end
    tick();
    redirect = 1'b0; redirect_target = 16'h0BAD;
    tick();
    imem_ack = 1'b1;
    #1;
    checks++; if (pc_enable !== 1'b1 || pc_in !== 16'h0100) begin failures++; $display("FAIL redir_pend_pc_in got=%0h/%0h exp=1/0100", pc_enable, pc_in); end
    tick();
    checks++; if (instr_valid !== 1'b0 || pc !== 16'h0100) begin failures++; $display("FAIL redir_discard got=%0h/%0h exp=0/0100", instr_valid, pc); end
    imem_rdata = 16'h1111;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin failures++; $display("FAIL redir_next_req got=%0h@%0h exp=1@0100", imem_req, imem_addr); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr !== 16'h1111 || pc !== 16'h0102) begin failures++; $display("FAIL redir_next_fetch got=%0h/%0h/%0h exp=1/1111/0102", instr_valid, instr, pc); end
  endtask

  task automatic test_stall_redirect();
    stall = 1'b1; redirect = 1'b1; redirect_target = 16'h0040;
    #1;
    checks++; if (imem_req !== 1'b0 || pc_enable !== 1'b1 || pc_in !== 16'h0040) begin failures++; $display("FAIL stall_redir got=%0h/%0h/%0h exp=0/1/0040", imem_req, pc_enable, pc_in); end
    tick();
    redirect = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || pc_enable !== 1'b0) begin failures++; $display("FAIL stall_only got=%0h/%0h exp=0/0", imem_req, pc_enable); end
    tick();
    checks++; if (pc !== 16'h0040 || instr_valid !== 1'b0) begin failures++; $display("FAIL stall_hold got=%0h/%0h exp=0040/0", pc, instr_valid); end
    stall = 1'b0;
  endtask

  task automatic test_halt_wrap();
    redirect = 1'b1; redirect_target = 16'hFFFE;
    tick();
    redirect = 1'b0; imem_ack = 1'b1; imem_rdata = 16'hF000;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'hFFFE || pc_in !== 16'h0000) begin failures++; $display("FAIL halt_req got=%0h@%0h in=%0h exp=1@FFFE in=0000", imem_req, imem_addr, pc_in); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr !== 16'hF000 || halted !== 1'b1 || pc !== 16'h0000) begin failures++; $display("FAIL halt_state got=%0h/%0h/%0h/%0h exp=1/F000/1/0000", instr_valid, instr, halted, pc); end
    #1;
    checks++; if (imem_req !== 1'b0 || pc_enable !== 1'b0) begin failures++; $display("FAIL halted_idle got=%0h/%0h exp=0/0", imem_req, pc_enable); end
    tick();
    checks++; if (halted !== 1'b1 || instr_valid !== 1'b0) begin failures++; $display("FAIL halted_stay got=%0h/%0h exp=1/0", halted, instr_valid); end
    resume = 1'b1;
    tick();
    resume = 1'b0; imem_rdata = 16'h2222;
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL resume_halted got=%0h exp=0", halted); end
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin failures++; $display("FAIL resume_req got=%0h@%0h exp=1@0000", imem_req, imem_addr); end
    tick();
    checks++; if (instr !== 16'h2222 || pc !== 16'h0002) begin failures++; $display("FAIL resume_fetch got=%0h/%0h exp=2222/0002", instr, pc); end
  endtask

  task automatic test_timeout();
    imem_ack = 1'b0;
    tick();
    for (int k = 1; k <= 15; k++) begin
      checks++; if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin failures++; $display("FAIL to_wait[%0d] got=%0h/%0h exp=1/0", k, imem_req, fetch_err); end
      tick();
    end
    checks++; if (fetch_err !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0) begin failures++; $display("FAIL to_fire got=%0h/%0h/%0h exp=1/1/0", fetch_err, halted, imem_req); end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    checks++; if (fetch_err !== 1'b1 || halted !== 1'b0) begin failures++; $display("FAIL to_sticky got=%0h/%0h exp=1/0", fetch_err, halted); end
    tick();
    rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_mid_req got=%0h exp=0", imem_req); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (fetch_err !== 1'b0 || pc_enable !== 1'b1 || pc_in !== 16'h0000) begin failures++; $display("FAIL rst_clear got=%0h/%0h/%0h exp=0/1/0000", fetch_err, pc_enable, pc_in); end
    tick();
  endtask

  initial begin
    test_reset();
    test_seq_fetch();
    test_wait_states();
    test_redirect_wait();
    test_stall_redirect();
    test_halt_wrap();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Fetch controller that sequences the 16-bit program-counter register (pc) and the instruction-memory read port. Each cycle it decides whether the pc loads the reset vector, the sequential address, a redirect target, or holds. It runs the req/ack handshake with instruction memory, delivers fetched instructions to decode, and handles stall, halt, resume and fetch timeout. It sits between the pc register, imem and the decode/branch logic.

Parameters:
RESET_VEC, 16'h0000, address loaded into pc after reset
PC_INC, 2, sequential increment, added modulo 2^16
HALT_OP, 4'hF, opcode (imem_rdata[15:12]) that halts fetch
TIMEOUT, 15, max WAIT cycles without imem_ack before error
CNT_W, 4, timeout counter width; must satisfy TIMEOUT < 2^CNT_W

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  decode back-pressure; blocks a new request in FETCH
redirect  in  1  branch/jump taken, one-cycle qualifier
redirect_target  in  16  new pc when redirect=1
resume  in  1  leave HALTED, continue at current pc
pc_addr  in  16  current pc register output
pc_enable  out  1  pc load strobe (combinational)
pc_in  out  16  pc load value (combinational)
imem_req  out  1  instruction read request (combinational)
imem_addr  out  16  equals pc_addr
imem_ack  in  1  read complete, imem_rdata valid this cycle
imem_rdata  in  16  instruction word
instr  out  16  last delivered instruction (registered)
instr_valid  out  1  one-cycle pulse, instr is new (registered)
halted  out  1  high while in HALTED (registered)
fetch_err  out  1  sticky timeout flag, cleared only by rst

Behaviour:
- States: BOOT, FETCH, WAIT, HALTED. rst=1 -> state BOOT, instr=0, instr_valid=0, halted=0, fetch_err=0, counter=0, pending cleared. pc_enable=0 and imem_req=0 while rst=1.
- Default every cycle: pc_enable=0, imem_req=0, instr_valid next=0.
- BOOT: pc_enable=1, pc_in=RESET_VEC -> FETCH. Redirect is ignored.
- FETCH, priority order:
  - redirect: pc_enable=1, pc_in=redirect_target, no request, stay in FETCH.
  - stall: hold everything, stay in FETCH.
  - otherwise imem_req=1. With imem_ack this cycle, complete (see below). Without imem_ack -> WAIT, counter=0.
- WAIT: imem_req=1, imem_addr held (pc not written). Once imem_req is asserted it stays high until ack; stall is ignored.
  - redirect without ack: latch pending_target, latest wins.
  - no ack: counter++. When counter reaches TIMEOUT with no ack: fetch_err<=1, halted<=1, pending cleared, -> HALTED.
- Completion, on ack in FETCH or WAIT, priority order:
  - redirect this cycle: pc_in=redirect_target; fetched word discarded, instr_valid stays 0.
  - else pending set: pc_in=pending_target, word discarded, pending cleared.
  - else opcode==HALT_OP: instr<=rdata, instr_valid<=1, pc_in=pc_addr+PC_INC, halted<=1 -> HALTED.
  - else: instr<=rdata, instr_valid<=1, pc_in=pc_addr+PC_INC -> FETCH.
  - pc_enable=1 in every completion case.
- HALTED: no requests.
  - redirect: pc load, halted<=0 -> FETCH; redirect has priority over resume.
  - resume: halted<=0 -> FETCH.
  - imem_ack in HALTED is ignored.
- Arithmetic: 16-bit wrap, 16'hFFFE+2 = 16'h0000. No carry out.
- Latency: pc changes on the edge after pc_enable. Minimum 1 cycle per instruction with zero-wait memory. instr_valid rises the cycle after ack.
- Reset mid-transaction: outstanding request is abandoned and imem_req drops in the rst cycle.

Test Plan:
- Boot and sequential fetch: rst 2 cycles, imem_ack tied 1, rdata=16'h1234 -> pc 0000,0002,0004; instr_valid high each cycle after BOOT; instr=1234.
- Wait states: ack 3 cycles after req -> imem_req high 4 cycles at addr 0004, pc stable; then one instr_valid pulse; pc=0006.
- Redirect during WAIT: redirect, target=0x0100 in WAIT, ack 2 cycles later -> instr_valid stays 0, pc=0100, next req addr=0100.
- Stall vs redirect in FETCH: stall=1 and redirect=1 with target 0x0040 -> no req, pc=0040. Then stall=1 alone -> req low, pc held.
- Halt/resume and wrap: pc=FFFE, rdata=F000 -> instr_valid=1, pc=0000, halted=1, no req. resume pulse -> halted=0, req at 0000.
- Timeout: ack never asserted -> after TIMEOUT=15 WAIT cycles fetch_err=1, halted=1, req low. fetch_err stays 1 through resume; rst clears it.
